ofdm_sym_sched: RTL and testbench

Symbol/frame scheduler placed between the QAM mapper's Wishbone-style stream and the pilot-insertion stage of the 802.22 OFDM transmitter. It cuts the continuous data-carrier stream into bursts of exactly one symbol's worth of data carriers, and frames each burst with a CYC_O rising edge that restarts the downstream pilot/null/allocation sequence. It enforces an inter-symbol gap and counts symbols per frame. It also reports frame boundaries and truncated-symbol errors to the MAC-side control.

---
 rtl/ofdm_sym_sched.sv | 163 ++++++++++++++++
 tb/tb_ofdm_sym_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_sym_sched.sv
// rtl/ofdm_sym_sched.sv - OFDM symbol/frame scheduler between QAM mapper and pilot insertion
module ofdm_sym_sched #(
    parameter int DATA_PER_SYM  = 1440,
    parameter int SYM_PER_FRAME = 26,
    parameter int GAP_CYC       = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        EN_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic        DN_BUSY_I,
    output logic [4:0]  SYM_IDX_O,
    output logic        FRM_START_O,
    output logic        FRM_DONE_O,
    output logic        ERR_O
);

    // Gap counter only needs to reach GAP_CYC-1, where it saturates.
    localparam int              GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [10:0]     LAST_BEAT = 11'(DATA_PER_SYM - 1);
    localparam logic [4:0]      LAST_SYM  = 5'(SYM_PER_FRAME - 1);
    localparam logic [GW-1:0]   GAP_END   = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_BURST,
        S_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [10:0]    r_beat_cnt;
    logic [GW-1:0]  r_gap_cnt;
    logic [4:0]     r_sym_idx;
    logic           r_frm_first;
    logic           r_frm_start;
    logic           r_frm_done;
    logic           r_err;

    logic           w_req;
    logic           w_burst;
    logic           w_stb;
    logic           w_beat;
    logic           w_last;
    logic           w_abort;
    logic           w_enter_burst;
    logic           w_gap_done;
    logic           w_frm_end;

    // Decode handshake conditions, next state and the pass-through data path.
    always_comb begin
        w_state_nxt   = r_state;
        w_req         = CYC_I & STB_I & WE_I;
        w_burst       = (r_state == S_BURST);
        w_stb         = w_burst & STB_I & WE_I;
        w_beat        = w_stb & ACK_I;
        w_last        = w_beat & (r_beat_cnt == LAST_BEAT);
        w_abort       = w_burst & ~CYC_I;
        w_enter_burst = (r_state == S_ARM) & w_req & ~DN_BUSY_I;
        w_gap_done    = (r_state == S_GAP) & (r_gap_cnt == GAP_END) & ~DN_BUSY_I;
        w_frm_end     = w_gap_done & (r_sym_idx == LAST_SYM);

        // Data is only steered downstream while a symbol burst is open.
        CYC_O       = w_burst;
        STB_O       = w_stb;
        WE_O        = w_stb;
        ACK_O       = w_stb & ACK_I;
        DAT_O       = w_burst ? DAT_I : 32'd0;
        SYM_IDX_O   = r_sym_idx;
        FRM_START_O = r_frm_start;
        FRM_DONE_O  = r_frm_done;
        ERR_O       = r_err;

        case (r_state)
            S_IDLE:  if (EN_I) w_state_nxt = S_ARM;
            S_ARM:   if (w_enter_burst) w_state_nxt = S_BURST;
            S_BURST: if (w_abort || w_last) w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_gap_done) begin
                    // Stop requests only take effect at a frame boundary.
                    w_state_nxt = (w_frm_end && !EN_I) ? S_IDLE : S_ARM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset drops CYC_O immediately by forcing IDLE.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Beat/gap/symbol counters plus the registered frame pulses and sticky error.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_sym_idx   <= '0;
            r_frm_first <= 1'b0;
            r_frm_start <= 1'b0;
            r_frm_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_frm_start <= 1'b0;
            r_frm_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (EN_I) begin
                        r_sym_idx   <= '0;
                        r_frm_first <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (w_enter_burst) begin
                        r_frm_start <= r_frm_first;
                        r_frm_first <= 1'b0;
                        r_beat_cnt  <= '0;
                        if (r_frm_first) r_err <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (w_abort) begin
                        // Truncated symbol still occupies its slot in the frame.
                        r_err      <= 1'b1;
                        r_beat_cnt <= '0;
                        r_gap_cnt  <= '0;
                    end else if (w_last) begin
                        r_beat_cnt <= '0;
                        r_gap_cnt  <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 11'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != GAP_END) r_gap_cnt <= r_gap_cnt + 1'b1;
                    if (w_gap_done) begin
                        if (w_frm_end) begin
                            r_sym_idx   <= '0;
                            r_frm_done  <= 1'b1;
                            r_frm_first <= EN_I;
                        end else begin
                            r_sym_idx   <= r_sym_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// tb/tb_ofdm_sym_sched.sv - directed self-checking bench for ofdm_sym_sched
module tb_ofdm_sym_sched;

    localparam int          DPS  = 8;
    localparam int          SPF  = 3;
    localparam int          GAPC = 4;
    localparam logic [31:0] BASE = 32'hA500_0000;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        EN_I;
    logic [31:0] DAT_I;
    logic        CYC_I, STB_I, WE_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O, STB_O, WE_O;
    logic        ACK_I;
    logic        DN_BUSY_I;
    logic [4:0]  SYM_IDX_O;
    logic        FRM_START_O, FRM_DONE_O, ERR_O;

    always #5 CLK_I = ~CLK_I;

    ofdm_sym_sched #(
        .DATA_PER_SYM  (DPS),
        .SYM_PER_FRAME (SPF),
        .GAP_CYC       (GAPC)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .EN_I        (EN_I),
        .DAT_I       (DAT_I),
        .CYC_I       (CYC_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ACK_O       (ACK_O),
        .DAT_O       (DAT_O),
        .CYC_O       (CYC_O),
        .STB_O       (STB_O),
        .WE_O        (WE_O),
        .ACK_I       (ACK_I),
        .DN_BUSY_I   (DN_BUSY_I),
        .SYM_IDX_O   (SYM_IDX_O),
        .FRM_START_O (FRM_START_O),
        .FRM_DONE_O  (FRM_DONE_O),
        .ERR_O       (ERR_O)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int n_start, n_done, n_rise, n_fall, cur_beats, low_run, data_bad, proto_bad;
    int word;
    bit prev_cyc, bp;
    int beats_hist[8], sym_at_rise[8], start_at_rise[8], gap_at_rise[8], err_at_rise[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_start = 0; n_done = 0; n_rise = 0; n_fall = 0; cur_beats = 0;
        low_run = 0; data_bad = 0; proto_bad = 0; prev_cyc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beats_hist[k] = -1; sym_at_rise[k] = -1; start_at_rise[k] = -1;
            gap_at_rise[k] = -1; err_at_rise[k] = -1;
        end
    endtask

    // One clock: observe at negedge, then update upstream/ack drive 1 ns after posedge.
    task automatic tick();
        bit acked;
        @(negedge CLK_I);
        acked = 1'b0;
        if (FRM_START_O) n_start++;
        if (FRM_DONE_O)  n_done++;
        if (ACK_O && !CYC_O) proto_bad++;
        if (CYC_O) begin
            if (!prev_cyc) begin
                if (n_rise < 8) begin
                    sym_at_rise[n_rise]   = int'(SYM_IDX_O);
                    start_at_rise[n_rise] = int'(FRM_START_O);
                    gap_at_rise[n_rise]   = low_run;
                    err_at_rise[n_rise]   = int'(ERR_O);
                end
                n_rise++;
            end else if (n_rise >= 1 && n_rise <= 8 && int'(SYM_IDX_O) != sym_at_rise[n_rise-1]) begin
                proto_bad++;
            end
            low_run = 0;
        end else begin
            if (prev_cyc) begin
                if (n_fall < 8) beats_hist[n_fall] = cur_beats;
                n_fall++;
                cur_beats = 0;
            end
            low_run++;
        end
        if (ACK_O) begin
            if (DAT_O !== BASE + 32'(word)) data_bad++;
            cur_beats++;
            acked = 1'b1;
        end
        prev_cyc = CYC_O;
        @(posedge CLK_I);
        #1;
        if (acked) begin
            word++;
            DAT_I = BASE + 32'(word);
        end
        if (bp) ACK_I = ~ACK_I;
    endtask

    task automatic wait_done(input int drop_at, input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) begin
            tick();
            if (n_rise >= drop_at) EN_I = 1'b0;
        end
        chk("frame_done", n_done, 1);
    endtask

    task automatic chk_bursts(input string tag, input int first_beats);
        chk({tag, "_rises"}, n_rise, SPF);
        chk({tag, "_beats0"}, beats_hist[0], first_beats);
        for (int k = 1; k < SPF; k++) chk({tag, "_beats"}, beats_hist[k], DPS);
        for (int k = 0; k < SPF; k++) chk({tag, "_symidx"}, sym_at_rise[k], k);
        chk({tag, "_data"}, data_bad, 0);
        chk({tag, "_proto"}, proto_bad, 0);
    endtask

    initial begin
        RST_I = 1'b0; EN_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ACK_I = 1'b1; DN_BUSY_I = 1'b0; bp = 1'b0; word = 0; DAT_I = BASE;
        clr_mon();

        // Reset state: outputs quiet even with an active upstream and enable
        repeat (2) @(posedge CLK_I);
        #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; EN_I = 1'b1;
        @(posedge CLK_I);
        #2;
        chk("rst_ctrl", 32'({CYC_O, STB_O, WE_O, ACK_O, FRM_START_O, FRM_DONE_O, ERR_O, SYM_IDX_O}), 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        clr_mon();

        // Frame of 3 symbols; EN_I dropped during symbol 1 stops after the frame
        wait_done(2, 300);
        repeat (30) tick();
        chk_bursts("t1", DPS);
        chk("t1_start_cnt", n_start, 1);
        chk("t1_start_first", start_at_rise[0], 1);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_gap1", gap_at_rise[1], 5);
        chk("t1_gap2", gap_at_rise[2], 5);
        chk("t1_words", word, SPF * DPS);
        chk("t1_idle_cyc", CYC_O, 0);
        chk("t1_idle_sym", SYM_IDX_O, 0);

        // Backpressure: ACK_I alternates every cycle
        clr_mon();
        EN_I = 1'b1; bp = 1'b1;
        wait_done(1, 400);
        bp = 1'b0; ACK_I = 1'b1;
        repeat (5) tick();
        chk_bursts("t2", DPS);
        chk("t2_words", word, 2 * SPF * DPS);
        chk("t2_start_cnt", n_start, 1);

        // DN_BUSY_I held for 20 cycles after the first burst stretches the gap
        clr_mon();
        EN_I = 1'b1;
        for (int i = 0; i < 100 && n_fall == 0; i++) begin
            tick();
            if (n_rise >= 1) EN_I = 1'b0;
        end
        chk("t3_burst0_end", n_fall, 1);
        DN_BUSY_I = 1'b1;
        repeat (20) tick();
        chk("t3_busy_cyc", CYC_O, 0);
        chk("t3_busy_rises", n_rise, 1);
        DN_BUSY_I = 1'b0;
        wait_done(1, 300);
        chk_bursts("t3", DPS);
        chk("t3_gap_busy", gap_at_rise[1], 23);
        chk("t3_gap_norm", gap_at_rise[2], 5);

        // Upstream drops CYC_I after 5 beats: truncated symbol, sticky error
        clr_mon();
        EN_I = 1'b1;
        for (int i = 0; i < 100 && cur_beats < 5; i++) begin
            tick();
            if (n_rise >= 1) EN_I = 1'b0;
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        repeat (3) tick();
        chk("t4_err_set", ERR_O, 1);
        chk("t4_cyc_low", CYC_O, 0);
        CYC_I = 1'b1; STB_I = 1'b1;
        wait_done(1, 300);
        repeat (3) tick();
        chk_bursts("t4", 5);
        chk("t4_err_sticky", ERR_O, 1);
        chk("t4_err_at_start", err_at_rise[0], 0);

        // Next frame start clears ERR_O; then reset mid-burst
        clr_mon();
        EN_I = 1'b1;
        for (int i = 0; i < 20 && n_rise == 0; i++) tick();
        chk("t5_rise", n_rise, 1);
        chk("t5_err_cleared", err_at_rise[0], 0);
        chk("t5_start_pulse", start_at_rise[0], 1);
        for (int i = 0; i < 20 && cur_beats < 3; i++) tick();
        chk("t5_in_burst", CYC_O, 1);
        #2;
        RST_I = 1'b0;
        #1;
        chk("t5_async_ctrl", 32'({CYC_O, STB_O, WE_O, ACK_O, FRM_START_O, FRM_DONE_O, ERR_O, SYM_IDX_O}), 32'd0);
        chk("t5_async_dat", DAT_O, 32'd0);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        clr_mon();
        for (int i = 0; i < 20 && n_rise == 0; i++) tick();
        chk("t6_rise", n_rise, 1);
        chk("t6_sym0", sym_at_rise[0], 0);
        chk("t6_start_pulse", start_at_rise[0], 1);
        EN_I = 1'b0;
        wait_done(1, 300);
        chk_bursts("t6", DPS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
